// File: rtl/reg_file_pkg.sv
// Shared CPU definitions: default register-file geometry and the ALU operation encoding.
package reg_file_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int NUM_REGS_DEF   = 32;
    localparam int ADDR_WIDTH_DEF = $clog2(NUM_REGS_DEF);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_SLL  = 4'h5,
        ALU_SRL  = 4'h6,
        ALU_SRA  = 4'h7,
        ALU_SLT  = 4'h8,
        ALU_SLTU = 4'h9
    } alu_op_e;

endpackage

// File: rtl/reg_file_scoreboard.sv
// Busy-bit scoreboard: one outstanding-producer flag per register, with two lookup ports.
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int NUM_REGS   = NUM_REGS_DEF,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    input  logic                  wb_en,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy
);

    logic [NUM_REGS-1:0] busy;
    logic                issue_hit;
    logic                wb_hit;

    assign issue_hit = issue_valid && (issue_rd != '0) && (int'(issue_rd) < NUM_REGS);
    assign wb_hit    = wb_en && (wb_addr != '0) && (int'(wb_addr) < NUM_REGS);

    // Set is applied after clear so a same-cycle issue to the written index wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (wb_hit)
                busy[wb_addr] <= 1'b0;
            if (issue_hit)
                busy[issue_rd] <= 1'b1;
        end
    end

    always_comb begin
        rs1_busy = 1'b0;
        rs2_busy = 1'b0;
        if (!rst && rs1_addr != '0 && int'(rs1_addr) < NUM_REGS)
            rs1_busy = busy[rs1_addr] && !(wb_en && wb_addr == rs1_addr);
        if (!rst && rs2_addr != '0 && int'(rs2_addr) < NUM_REGS)
            rs2_busy = busy[rs2_addr] && !(wb_en && wb_addr == rs2_addr);
    end

endmodule

// File: rtl/reg_file.sv
// Architectural register file: x0 hard-wired to zero, writeback bypass on both read ports.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_REGS   = NUM_REGS_DEF,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    output logic [DATA_WIDTH-1:0] rs1_data,
    output logic [DATA_WIDTH-1:0] rs2_data,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    input  logic                  wb_en,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data
);

    logic [DATA_WIDTH-1:0] regs [0:NUM_REGS-1];
    logic                  wb_hit;

    assign wb_hit = wb_en && (wb_addr != '0) && (int'(wb_addr) < NUM_REGS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (wb_hit) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Index 0 and out-of-range indices read as zero; the bypass never applies to x0.
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (!rst && rs1_addr != '0 && int'(rs1_addr) < NUM_REGS)
            rs1_data = (wb_en && wb_addr == rs1_addr) ? wb_data : regs[rs1_addr];
        if (!rst && rs2_addr != '0 && int'(rs2_addr) < NUM_REGS)
            rs2_data = (wb_en && wb_addr == rs2_addr) ? wb_data : regs[rs2_addr];
    end

    reg_scoreboard #(
        .NUM_REGS   (NUM_REGS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy)
    );

endmodule

// File: tb/tb_reg_file.sv
// Randomized bench for reg_file against an array-based model, plus directed literal checks.
`timescale 1ns/1ps
module tb_reg_file;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        rs1_busy, rs2_busy;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_regs [32];
    bit          m_busy [32];

    reg_file dut (
        .clk         (clk),
        .rst         (rst),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: arrays of values and busy flags, updated from the rules at each edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 32'h0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (wb_en && wb_addr != 0) begin
                m_regs[wb_addr] = wb_data;
                m_busy[wb_addr] = 1'b0;
            end
            if (issue_valid && issue_rd != 0)
                m_busy[issue_rd] = 1'b1;
        end
    end

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        if (rst || a == 0) return 32'h0;
        if (wb_en && wb_addr == a) return wb_data;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (rst || a == 0) return 1'b0;
        if (wb_en && wb_addr == a) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Continuous compare against the model, mid-way through each low phase.
    always @(negedge clk) begin
        #2;
        chk("rs1_data", rs1_data, exp_data(rs1_addr));
        chk("rs2_data", rs2_data, exp_data(rs2_addr));
        chk("rs1_busy", {31'h0, rs1_busy}, {31'h0, exp_busy(rs1_addr)});
        chk("rs2_busy", {31'h0, rs2_busy}, {31'h0, exp_busy(rs2_addr)});
    end

    task automatic cyc(input logic iv, input logic [4:0] ird,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] a1, input logic [4:0] a2);
        @(negedge clk);
        issue_valid = iv;
        issue_rd    = ird;
        wb_en       = we;
        wb_addr     = wa;
        wb_data     = wd;
        rs1_addr    = a1;
        rs2_addr    = a2;
        #1;
    endtask

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        rst = 1'b1;
        issue_valid = 1'b0; issue_rd = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        rs1_addr = '0; rs2_addr = '0;
        repeat (3) @(posedge clk);

        // Reset state readback.
        cyc(0, 0, 0, 0, 0, 5, 31);
        rst = 1'b0;
        #1;
        chk("rst_rs1_data", rs1_data, 32'h0);
        chk("rst_rs2_data", rs2_data, 32'h0);
        chk("rst_rs1_busy", {31'h0, rs1_busy}, 32'h0);
        chk("rst_rs2_busy", {31'h0, rs2_busy}, 32'h0);

        // Write x3 then read it back next cycle.
        cyc(0, 0, 1, 3, 32'hDEADBEEF, 0, 0);
        cyc(0, 0, 0, 0, 0, 3, 0);
        chk("x3_read", rs1_data, 32'hDEADBEEF);

        // Writes to x0 are discarded, including the bypass.
        cyc(0, 0, 1, 0, 32'h1234, 0, 0);
        chk("x0_same", rs1_data, 32'h0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("x0_next", rs1_data, 32'h0);

        // Dual-port bypass on x7 while it is busy.
        cyc(1, 7, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 7, 32'hA5A5A5A5, 7, 7);
        chk("byp_rs1_data", rs1_data, 32'hA5A5A5A5);
        chk("byp_rs2_data", rs2_data, 32'hA5A5A5A5);
        chk("byp_rs1_busy", {31'h0, rs1_busy}, 32'h0);
        chk("byp_rs2_busy", {31'h0, rs2_busy}, 32'h0);

        // Issue vs writeback collision on x9: set wins.
        cyc(1, 9, 0, 0, 0, 0, 0);
        cyc(1, 9, 1, 9, 32'h99, 0, 0);
        cyc(0, 0, 0, 0, 0, 9, 0);
        chk("x9_busy_after_collide", {31'h0, rs1_busy}, 32'h1);
        chk("x9_data_after_collide", rs1_data, 32'h99);
        cyc(0, 0, 1, 9, 32'h100, 0, 0);
        cyc(0, 0, 0, 0, 0, 9, 0);
        chk("x9_busy_cleared", {31'h0, rs1_busy}, 32'h0);
        chk("x9_data_final", rs1_data, 32'h100);

        // Randomized traffic, including occasional reset cycles with live writes/issues.
        for (int n = 0; n < 600; n++) begin
            cyc($urandom_range(0, 9) < 4, rnd_addr(),
                $urandom_range(0, 1) == 1, rnd_addr(), $urandom,
                rnd_addr(), rnd_addr());
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
            end
        end

        // Mark several registers busy so the async clear below is observable.
        for (int r = 1; r < 32; r += 3)
            cyc(1, 5'(r), 0, 0, 0, 0, 0);

        // Async reset pulse between edges wipes x4.
        cyc(0, 0, 1, 4, 32'h55, 0, 0);
        cyc(0, 0, 0, 0, 0, 4, 4);
        chk("x4_before_rst", rs1_data, 32'h55);
        #2 rst = 1'b1;
        #1 chk("x4_during_rst", rs1_data, 32'h0);
        rst = 1'b0;
        #0.5 chk("x4_after_rst", rs1_data, 32'h0);
        chk("x4_busy_after_rst", {31'h0, rs2_busy}, 32'h0);

        for (int r = 0; r < 16; r++)
            cyc(0, 0, 0, 0, 0, 5'(r), 5'(r + 16));
        for (int r = 1; r < 32; r++)
            cyc(0, 0, 0, 0, 0, 5'(r), 0);
        chk("post_rst_busy_last", {31'h0, rs1_busy}, 32'h0);

        @(negedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 32, number of architectural registers.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(NUM_REGS) = 5, register index width.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port rs1_addr  input  ADDR_WIDTH  source-1 index.
REQ-007 SHALL have port rs2_addr  input  ADDR_WIDTH  source-2 index.
REQ-008 SHALL have port rs1_data  output  DATA_WIDTH  source-1 value; drives ALU operand1.
REQ-009 SHALL have port rs2_data  output  DATA_WIDTH  source-2 value; drives ALU operand2 for register-register ops.
REQ-010 SHALL have port rs1_busy  output  1  source-1 has an outstanding producer.
REQ-011 SHALL have port rs2_busy  output  1  source-2 has an outstanding producer.
REQ-012 SHALL have port issue_valid  input  1  an instruction writing issue_rd is issued this cycle.
REQ-013 SHALL have port issue_rd  input  ADDR_WIDTH  destination of the issuing instruction.
REQ-014 SHALL have port wb_en  input  1  writeback valid this cycle.
REQ-015 SHALL have port wb_addr  input  ADDR_WIDTH  writeback destination.
REQ-016 SHALL have port wb_data  input  DATA_WIDTH  writeback value, i.e. ALU result.

Function
REQ-017 SHALL hold NUM_REGS x DATA_WIDTH storage plus one busy bit per register.
REQ-018 SHALL read combinationally: rsN_data = reg[rsN_addr], zero-latency.
REQ-019 SHALL return 0 and busy=0 for index 0 regardless of writes or issues.
REQ-020 SHALL write reg[wb_addr] <= wb_data at the rising edge when wb_en=1 and wb_addr!=0; wb to index 0 is discarded.
REQ-021 SHALL bypass: when wb_en=1, wb_addr==rsN_addr, and rsN_addr!=0, rsN_data = wb_data in the same cycle.
REQ-022 SHALL bypass both ports independently when rs1_addr==rs2_addr==wb_addr.
REQ-023 SHALL set busy[issue_rd] at the edge when issue_valid=1 and issue_rd!=0.
REQ-024 SHALL clear busy[wb_addr] at the edge when wb_en=1 and wb_addr!=0.
REQ-025 SHALL give set priority when issue and writeback target the same index in one cycle: busy ends at 1.
REQ-026 SHALL drive rsN_busy = busy[rsN_addr] & ~(wb_en & wb_addr==rsN_addr), so a same-cycle writeback reports not-busy.
REQ-027 SHALL allow wb_en to an index whose busy bit is 0: data is written, busy stays 0, no error.
REQ-028 SHALL not let issue of a busy index change stored data; busy remains 1.
REQ-029 SHALL suppress bypass and force all outputs to 0 while rst=1.

Reset
REQ-030 SHALL, on assertion of rst and independent of clk, clear all registers to 0 and all busy bits to 0.
REQ-031 SHALL, on rst asserted mid-operation, discard any same-cycle write or issue; no edge while rst=1 updates state.
REQ-032 SHALL resume normal operation at the first rising edge after rst deasserts.

Structure
REQ-033 SHALL take DATA_WIDTH, NUM_REGS and ADDR_WIDTH defaults from the shared CPU package, alongside the ALU op enum.
REQ-034 SHALL keep busy-bit logic in one sub-module, reg_scoreboard, with ports clk, rst, issue, writeback and two lookup ports; the data array stays in reg_file.

Verification
REQ-035 SHALL cover: reset, then read rs1=5, rs2=31 -> both data 0 and busy 0.
REQ-036 SHALL cover: wb_en, wb_addr=3, wb_data=0xDEADBEEF; next cycle rs1_addr=3 -> rs1_data=0xDEADBEEF.
REQ-037 SHALL cover: wb_en, wb_addr=0, wb_data=0x1234 with rs1_addr=0 same and next cycle -> rs1_data=0 both cycles.
REQ-038 SHALL cover: rs1_addr=rs2_addr=7 with wb_en, wb_addr=7, wb_data=0xA5A5A5A5 same cycle -> both data 0xA5A5A5A5, both busy 0.
REQ-039 SHALL cover: issue_rd=9, then issue_rd=9 plus wb_addr=9 in one cycle -> rs1_addr=9 busy=1 after; a later lone wb to 9 -> busy=0.
REQ-040 SHALL cover: write x4=0x55, pulse rst between edges -> rs1_addr=4 reads 0 immediately, busy bits all 0.
